ripple_carry_adder: RTL and testbench

//  - WIDTH-bit unsigned binary adder, built as a chain of 1-bit full adders with carry-in and carry-out.
//  - Used as a leaf arithmetic block wherever a small, area-cheap adder is needed.
//  - Default build is purely combinational; an optional output register stage is selected at compile time.

---
 rtl/rca_pkg.sv | 22 ++
 rtl/ripple_carry_adder_full_adder.sv | 22 ++
 rtl/ripple_carry_adder.sv | 59 +++++
 tb/tb_ripple_carry_adder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_pkg
// Description : Shared constants and {carry, sum} golden function for the RCA.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 4;
  localparam int RCA_REF_MAX       = 32;

  // Operands are zero-extended to RCA_REF_MAX bits; callers slice [WIDTH:0].
  function automatic logic [RCA_REF_MAX:0] rca_ref(
    input logic [RCA_REF_MAX-1:0] a,
    input logic [RCA_REF_MAX-1:0] b,
    input logic                   cin
  );
    return {1'b0, a} + {1'b0, b} + {{RCA_REF_MAX{1'b0}}, cin};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder cell used as the ripple-carry stage.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_half;

  assign w_half = a ^ b;
  assign s      = w_half ^ cin;
  assign cout   = (a & b) | (cin & w_half);

endmodule
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder
// Description : WIDTH-bit unsigned ripple-carry adder; define RCA_REG_OUT_EN
//               to register sum/carry (1-cycle latency, async active-low reset).
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             carry,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] w_sum;

  assign c[0] = cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (c[i]),
        .s    (w_sum[i]),
        .cout (c[i+1])
      );
    end
  endgenerate

`ifdef RCA_REG_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      sum   <= w_sum;
      carry <= c[WIDTH];
    end
  end
`else
  // Clock and reset exist only for port compatibility with the registered build.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};

  assign sum   = w_sum;
  assign carry = c[WIDTH];
`endif

endmodule
`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_carry_adder
// Description : Self-checking bench for ripple_carry_adder (either build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_carry_adder;
  import rca_pkg::*;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         carry;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .carry (carry),
    .sum   (sum)
  );

  // Reference: plain integer addition truncated to W+1 bits.
  function automatic logic [W:0] model(input int unsigned x, input int unsigned y,
                                       input int unsigned ci);
    int unsigned t;
    t = x + y + ci;
    return t[W:0];
  endfunction

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed carry,sum=%b expected %b", tag, got, exp);
    end
  endtask

  // Drive one operand set and check the result once it is visible.
  task automatic step(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                      input logic [W:0] exp, input string tag);
`ifdef RCA_REG_OUT_EN
    @(negedge clk);
    a = x; b = y; cin = ci;
    @(posedge clk);
    #1;
`else
    a = x; b = y; cin = ci;
    #10;
`endif
    check(tag, {carry, sum}, exp);
  endtask

  initial begin
    logic [RCA_REF_MAX:0] r;
    logic [W-1:0]         x, y;
    logic                 ci;

    #2;
`ifdef RCA_REG_OUT_EN
    check("reset_state", {carry, sum}, 5'b0_0000);
    a = 4'b1111; b = 4'b0000; cin = 1'b1;
    #1;
    check("reset_hold_inputs", {carry, sum}, 5'b0_0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("before_first_edge", {carry, sum}, 5'b0_0000);
    @(posedge clk);
    #1;
    check("first_edge_capture", {carry, sum}, 5'b1_0000);
`else
    rst_n = 1'b1;
`endif

    step(4'b0000, 4'b0000, 1'b0, 5'b0_0000, "dir_zero");
    step(4'b0001, 4'b0001, 1'b0, 5'b0_0010, "dir_one_plus_one");
    step(4'b1111, 4'b1111, 1'b0, 5'b1_1110, "dir_ones_plus_ones");
    step(4'b1010, 4'b0101, 1'b1, 5'b1_0000, "dir_full_ripple");
    step(4'b1100, 4'b1010, 1'b0, 5'b1_0110, "dir_1100_1010");
    step(4'b0111, 4'b0001, 1'b1, 5'b0_1001, "dir_0111_0001_c1");
    step(4'b1111, 4'b0000, 1'b1, 5'b1_0000, "dir_ones_plus_cin");

    for (int i = 0; i < 512; i++) begin
      x  = 4'(i >> 5);
      y  = 4'(i >> 1);
      ci = 1'(i);
      r  = rca_ref(32'(x), 32'(y), ci);
      check("rca_ref_vs_model", r[W:0], model(x, y, ci));
      step(x, y, ci, model(x, y, ci), "sweep");
    end

    for (int i = 0; i < 100; i++) begin
      x  = 4'($urandom);
      y  = 4'($urandom);
      ci = 1'($urandom);
      step(x, y, ci, model(x, y, ci), "random");
    end

`ifdef RCA_REG_OUT_EN
    // Mid-cycle reset: output clears at once and the in-flight sum is dropped.
    step(4'b0110, 4'b0101, 1'b0, 5'b0_1011, "pre_reset_value");
    @(negedge clk);
    a = 4'b1001; b = 4'b0011; cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", {carry, sum}, 5'b0_0000);
    @(posedge clk);
    #1;
    check("reset_held_low", {carry, sum}, 5'b0_0000);
    @(negedge clk);
    a = 4'b0011; b = 4'b0100; cin = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_capture", {carry, sum}, 5'b0_0111);
`else
    // Clock and reset must not disturb the combinational result.
    a = 4'b1011; b = 4'b0110; cin = 1'b1;
    #3;
    rst_n = 1'b0;
    #7;
    check("comb_ignores_rst", {carry, sum}, 5'b1_0010);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
